// File: rtl/pipeline_addsub.sv
// Segmented add/subtract pipeline with valid/ready flow control.
// Stage 0 registers operands; stages 1..NSEG each add one SEG-bit slice.
module pipeline_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int NSEG = WIDTH / SEG;

  logic [WIDTH-1:0] ra [0:NSEG];
  logic [WIDTH-1:0] rb [0:NSEG];
  logic [WIDTH-1:0] rs [0:NSEG];
  logic [NSEG:0]    rc;
  logic [NSEG:0]    rv;

  logic [WIDTH-1:0] ns [1:NSEG];
  logic [SEG:0]     t  [1:NSEG];
  logic [NSEG:0]    nc;
  logic             adv;

  assign adv      = !rv[NSEG] || out_ready;
  assign in_ready = adv;

  // stage k resolves slice k-1 and splices it into the partial result
  always_comb begin
    nc = '0;
    for (int k = 1; k <= NSEG; k++) begin
      t[k] = {1'b0, ra[k-1][(k-1)*SEG +: SEG]}
           + {1'b0, rb[k-1][(k-1)*SEG +: SEG]}
           + {{SEG{1'b0}}, rc[k-1]};
      ns[k] = rs[k-1];
      ns[k][(k-1)*SEG +: SEG] = t[k][SEG-1:0];
      nc[k] = t[k][SEG];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv <= '0;
      rc <= '0;
      for (int k = 0; k <= NSEG; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
    end else if (adv) begin
      rv[0] <= in_valid;
      ra[0] <= a;
      rb[0] <= sub ? ~b : b;
      rc[0] <= sub | ci;
      rs[0] <= '0;
      for (int k = 1; k <= NSEG; k++) begin
        rv[k] <= rv[k-1];
        ra[k] <= ra[k-1];
        rb[k] <= rb[k-1];
        rc[k] <= nc[k];
        rs[k] <= ns[k];
      end
    end
  end

  assign out_valid = rv[NSEG];
  assign s         = rs[NSEG];
  assign co        = rc[NSEG];
  assign ov        = (ra[NSEG][WIDTH-1] == rb[NSEG][WIDTH-1])
                  && (rs[NSEG][WIDTH-1] != ra[NSEG][WIDTH-1]);

endmodule

// File: tb/tb_pipeline_addsub.sv
// Scoreboard bench for pipeline_addsub: three parameterisations
// driven by shared stimulus, each with its own expected-result queue.
module tb_pipeline_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        ci;
  logic        sub;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic        rdy0, vo0, co0, ov0;
  logic [31:0] s0;
  logic        rdy1, vo1, co1, ov1;
  logic [15:0] s1;
  logic        rdy2, vo2, co2, ov2;
  logic [31:0] s2;

  int errors = 0;
  int checks = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];

  always #5 clk = ~clk;

  pipeline_addsub #(.WIDTH(32), .SEG(8)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(vo0), .out_ready(out_ready),
    .s(s0), .co(co0), .ov(ov0)
  );

  pipeline_addsub #(.WIDTH(16), .SEG(4)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub),
    .out_valid(vo1), .out_ready(out_ready),
    .s(s1), .co(co1), .ov(ov1)
  );

  pipeline_addsub #(.WIDTH(32), .SEG(32)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(vo2), .out_ready(out_ready),
    .s(s2), .co(co2), .ov(ov2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // plain w-bit two's-complement arithmetic
  function automatic logic [33:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic c, input logic sb,
                                        input int w);
    logic [63:0] m, xa, yb, sum, r;
    logic cy, o;
    m   = (64'd1 << w) - 64'd1;
    xa  = {32'd0, x} & m;
    yb  = (sb ? ~{32'd0, y} : {32'd0, y}) & m;
    sum = xa + yb + (sb ? 64'd1 : {63'd0, c});
    r   = sum & m;
    cy  = sum[w];
    o   = (xa[w-1] == yb[w-1]) && (r[w-1] != xa[w-1]);
    return {o, cy, r[31:0]};
  endfunction

  // issue side: record expectation on every accepted operation
  always @(negedge clk) begin
    if (!rst && in_valid) begin
      if (rdy0) q0.push_back(model(a, b, ci, sub, 32));
      if (rdy1) q1.push_back(model(a, b, ci, sub, 16));
      if (rdy2) q2.push_back(model(a, b, ci, sub, 32));
    end
  end

  // monitor side: pop and compare on every output transfer
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end else if (out_ready) begin
      if (vo0) begin
        if (q0.size() == 0) chk("d0_unexpected", 64'(vo0), 64'd0);
        else begin
          e = q0.pop_front();
          chk("d0_result", 64'({ov0, co0, s0}), 64'(e));
        end
      end
      if (vo1) begin
        if (q1.size() == 0) chk("d1_unexpected", 64'(vo1), 64'd0);
        else begin
          e = q1.pop_front();
          chk("d1_result", 64'({ov1, co1, 16'h0, s1}), 64'(e));
        end
      end
      if (vo2) begin
        if (q2.size() == 0) chk("d2_unexpected", 64'(vo2), 64'd0);
        else begin
          e = q2.pop_front();
          chk("d2_result", 64'({ov2, co2, s2}), 64'(e));
        end
      end
    end
  end

  task automatic run_one(input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic sb,
                         input logic [31:0] es, input logic eco,
                         input logic eov);
    int l0, l1, l2;
    l0 = 0; l1 = 0; l2 = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; ci = c; sub = sb;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vo0 && l0 == 0) begin
        l0 = n;
        chk("dir_s", 64'(s0), 64'(es));
        chk("dir_co_ov", 64'({co0, ov0}), 64'({eco, eov}));
      end
      if (vo1 && l1 == 0) l1 = n;
      if (vo2 && l2 == 0) l2 = n;
    end
    chk("lat_32_8", 64'(l0), 64'd5);
    chk("lat_16_4", 64'(l1), 64'd5);
    chk("lat_32_32", 64'(l2), 64'd2);
  endtask

  task automatic drive_rand(input logic v);
    @(posedge clk); #1;
    in_valid = v;
    a = $urandom; b = $urandom;
    ci = 1'($urandom); sub = 1'($urandom);
    if ($urandom_range(0, 9) == 0) begin
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0;
    end
  endtask

  task automatic drain_check(input string nm);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk(nm, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] ss;
    logic        sco, sov;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'({vo0, vo1, vo2}), 64'd0);
    chk("rst_outs", 64'({co0, ov0, s0}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'({rdy0, rdy1, rdy2}), 64'b111);

    run_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    for (int i = 0; i < 100; i++)
      drive_rand($urandom_range(0, 3) != 0);
    drain_check("stream_drained");

    for (int i = 0; i < 8; i++) drive_rand(1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    ss = s0; sco = co0; sov = ov0;
    chk("bp_full", 64'(vo0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({vo0, co0, ov0, s0}), 64'({1'b1, sco, sov, ss}));
      chk("bp_in_ready", 64'({rdy0, rdy1, rdy2}), 64'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_rand(1'b1);
    drain_check("bp_drained");

    for (int i = 0; i < 3; i++) drive_rand(1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'({vo0, vo1, vo2}), 64'd0);
    chk("mid_rst_s", 64'(s0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'({rdy0, rdy1, rdy2}), 64'b111);
    repeat (8) @(posedge clk);
    run_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drain_check("final_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_addsub.md
PIPELINE_ADDSUB -- requirements
Module: pipeline_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, with NSEG = WIDTH/SEG >= 1.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: a/b/ci/sub carry a valid operation.
REQ-006 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port ci, input, 1: carry-in, used only when sub=0.
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: s/co/ov hold a valid result.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port s, output, WIDTH: sum/difference.
REQ-014 SHALL have port co, output, 1: carry-out; for subtract, 1 = no borrow.
REQ-015 SHALL have port ov, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL compute, for sub=0: {co,s} = a + b + ci, as a (WIDTH+1)-bit sum.
REQ-017 SHALL compute, for sub=1: {co,s} = a + ~b + 1, ignoring ci.
REQ-018 SHALL set ov = (a[MSB] == beff[MSB]) && (s[MSB] != a[MSB]), where beff is b for add and ~b for subtract.
REQ-019 SHALL define adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-020 SHALL advance every pipeline register, data and valid, only on rising clk edges with adv=1, and SHALL hold all registers when adv=0.
REQ-021 Stage 0 SHALL register a, beff, the effective carry-in, and in_valid on acceptance; an operation is accepted when in_valid=1 and in_ready=1.
REQ-022 Stage k (k = 1..NSEG) SHALL add segment k-1 (bits k*SEG-1 : (k-1)*SEG) plus the carry from stage k-1, and forward lower result bits and remaining upper operand bits.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 at acceptance) SHALL propagate as valid=0 and never assert out_valid.
REQ-024 Latency SHALL be exactly NSEG+1 advancing edges from acceptance to out_valid=1; with out_ready held 1, throughput SHALL be one result per cycle.
REQ-025 Results SHALL emerge in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 While out_valid=1 and out_ready=0, s/co/ov/out_valid SHALL remain stable and in_ready SHALL be 0.
REQ-027 With SEG=WIDTH, the block SHALL degenerate to a 2-stage (register + adder) pipeline with identical semantics.

Reset
REQ-028 Asserting rst SHALL immediately clear every stage valid bit, out_valid, s, co and ov to 0, regardless of clk.
REQ-029 Operations in flight at reset SHALL be discarded; after rst deasserts, in_ready SHALL be 1 and the first accepted operation SHALL follow REQ-024.

Verification
REQ-030 WIDTH=32, SEG=8: a=0xFFFFFFFF, b=0, ci=1, sub=0, out_ready=1 -> after 5 edges s=0x00000000, co=1, ov=0.
REQ-031 Signed overflow: a=0x7FFFFFFF, b=1, ci=0, sub=0 -> s=0x80000000, co=0, ov=1; subtract a=5, b=7, sub=1 -> s=0xFFFFFFFE, co=0, ov=0.
REQ-032 Back-to-back stream: 100 random add/sub operations, one per cycle, with interleaved bubbles -> results match the reference model in order, one per cycle after a 5-cycle fill.
REQ-033 Backpressure: deassert out_ready for 3 cycles while the pipeline is full -> outputs frozen, in_ready=0, no result lost or duplicated after release.
REQ-034 Reset mid-stream with 3 operations in flight -> out_valid=0 at once and none of the 3 results ever appears.
REQ-035 Parameter sweep: WIDTH=16/SEG=4 and WIDTH=32/SEG=32 -> latencies of 5 and 2 cycles respectively, and carry-chain cases (0xFFFF + 1) correct.
